// File: rtl/rm_stream_aligner.sv
// rm_stream_aligner
//   Element-realigning FIFO between a variable-offset/variable-count input
//   bus and a variable-offset/variable-count output bus. Supports burst-end
//   marking with partial-beat flush, per-element output strobes, and zeroing
//   of output elements whose strobe bit is low.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both high (push: ival&&irdy, pop: oval&&ordy). irdy does not depend
//   on ival, and oval does not depend on ordy.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ival/irdy         input group handshake
//   init              accepted group discards FIFO contents and starts a burst
//   ilast             accepted group ends the burst
//   ib/iofs/iec       input bus, first valid element, element count
//   oval/ordy         output beat handshake
//   ob/ostrb          output bus and per-element valid mask
//   olast             beat carries the final elements of the burst
//   oofs/oec          requested output placement offset and element count
//   oecv              elements actually delivered this beat
//   freeec/availec    registered free / available element counts
module rm_stream_aligner #(
   parameter int EW     = 8,
   parameter int IBEC   = 16,
   parameter int OBEC   = 16,
   parameter int FIFOEC = 32,
   localparam int FIFOECW = $clog2(FIFOEC + 1),
   localparam int IBECW   = $clog2(IBEC + 1),
   localparam int OBECW   = $clog2(OBEC + 1),
   localparam int IOFSW   = (IBEC > 1) ? $clog2(IBEC) : 1,
   localparam int OOFSW   = (OBEC > 1) ? $clog2(OBEC) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ival,
   output logic                irdy,
   input  logic                init,
   input  logic                ilast,
   input  logic [IBEC*EW-1:0]  ib,
   input  logic [IOFSW-1:0]    iofs,
   input  logic [IBECW-1:0]    iec,
   output logic                oval,
   input  logic                ordy,
   output logic [OBEC*EW-1:0]  ob,
   output logic [OBEC-1:0]     ostrb,
   output logic                olast,
   input  logic [OOFSW-1:0]    oofs,
   input  logic [OBECW-1:0]    oec,
   output logic [OBECW-1:0]    oecv,
   output logic [FIFOECW-1:0]  freeec,
   output logic [FIFOECW-1:0]  availec
);

   localparam int AW = (FIFOEC > 1) ? $clog2(FIFOEC) : 1;

   if (FIFOEC < IBEC || FIFOEC < OBEC) begin : g_depth_check
      $error("rm_stream_aligner: FIFOEC must be >= max(IBEC, OBEC)");
   end

   logic [EW-1:0]      mem_q [FIFOEC];
   logic [AW-1:0]      rptr_q, rptr_d;
   logic [AW-1:0]      wptr_q, wptr_d;
   logic [FIFOECW-1:0] freeec_q, freeec_d;
   logic [FIFOECW-1:0] availec_q, availec_d;
   logic               last_pend_q, last_pend_d;

   logic               push, pop;
   logic               wr_en  [IBEC];
   logic [AW-1:0]      wr_idx [IBEC];
   logic [EW-1:0]      wr_dat [IBEC];

   // Both operands are below FIFOEC, so one conditional subtract is enough
   // for any depth, power of two or not.
   function automatic logic [AW-1:0] wrap_sum(input int a, input int b);
      int s;
      s = a + b;
      if (s >= FIFOEC) s = s - FIFOEC;
      return AW'(s);
   endfunction

   // Ready looks only at registered freeec; a same-cycle pop never helps.
   assign irdy  = init | (!last_pend_q && (freeec_q >= FIFOECW'(iec)));
   assign push  = ival & irdy & ~rst;

   // last_pend forces a beat out even when fewer than oec elements remain
   // (including zero), so the burst end always reaches the consumer.
   assign oval  = ((availec_q >= FIFOECW'(oec)) && (availec_q != '0)) | last_pend_q;
   assign oecv  = (availec_q >= FIFOECW'(oec)) ? oec : OBECW'(availec_q);
   assign olast = last_pend_q && (availec_q <= FIFOECW'(oec));
   assign pop   = oval & ordy & ~rst;

   assign freeec  = freeec_q;
   assign availec = availec_q;

   // Write side: element iofs+k of ib lands at slot base+k.
   always_comb begin
      int base;
      int src;
      base = init ? 0 : int'(wptr_q);
      for (int k = 0; k < IBEC; k++) begin
         wr_en[k]  = push && (k < int'(iec));
         wr_idx[k] = wrap_sum(base, k);
         wr_dat[k] = '0;
         src       = int'(iofs) + k;
         for (int j = 0; j < IBEC; j++) begin
            if (j == src) wr_dat[k] = ib[j*EW +: EW];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < IBEC; k++) begin
         if (wr_en[k]) mem_q[wr_idx[k]] <= wr_dat[k];
      end
   end

   // Read side: purely from registered state, so a push is visible next cycle.
   always_comb begin
      int rel;
      ob    = '0;
      ostrb = '0;
      for (int e = 0; e < OBEC; e++) begin
         rel = e - int'(oofs);
         if (rel >= 0 && rel < int'(oecv)) begin
            ostrb[e]       = 1'b1;
            ob[e*EW +: EW] = mem_q[wrap_sum(int'(rptr_q), rel)];
         end
      end
   end

   always_comb begin
      rptr_d      = rptr_q;
      wptr_d      = wptr_q;
      freeec_d    = freeec_q;
      availec_d   = availec_q;
      last_pend_d = last_pend_q;
      if (push && init) begin
         // init discards everything, including a beat popped this cycle.
         rptr_d      = '0;
         wptr_d      = wrap_sum(0, int'(iec));
         availec_d   = FIFOECW'(iec);
         freeec_d    = FIFOECW'(FIFOEC - int'(iec));
         last_pend_d = ilast;
      end else begin
         if (pop)  rptr_d = wrap_sum(int'(rptr_q), int'(oecv));
         if (push) wptr_d = wrap_sum(int'(wptr_q), int'(iec));
         availec_d = FIFOECW'(int'(availec_q) + (push ? int'(iec) : 0)
                                              - (pop ? int'(oecv) : 0));
         freeec_d  = FIFOECW'(int'(freeec_q) - (push ? int'(iec) : 0)
                                             + (pop ? int'(oecv) : 0));
         if (pop && olast)  last_pend_d = 1'b0;
         if (push && ilast) last_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rptr_q      <= '0;
         wptr_q      <= '0;
         freeec_q    <= FIFOECW'(FIFOEC);
         availec_q   <= '0;
         last_pend_q <= 1'b0;
      end else begin
         rptr_q      <= rptr_d;
         wptr_q      <= wptr_d;
         freeec_q    <= freeec_d;
         availec_q   <= availec_d;
         last_pend_q <= last_pend_d;
      end
   end

   a_in_legal: assert property (@(posedge clk) disable iff (rst)
      ival |-> (int'(iofs) + int'(iec) <= IBEC));
   a_out_legal: assert property (@(posedge clk) disable iff (rst)
      (int'(oofs) + int'(oec) <= OBEC));

endmodule

// File: tb/tb_rm_stream_aligner.sv
module tb_rm_stream_aligner;

   localparam int EW = 8;
   localparam int IBEC = 4;
   localparam int OBEC = 4;
   localparam int FIFOEC = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ival = 1'b0, init = 1'b0, ilast = 1'b0, ordy = 1'b0;
   logic [31:0] ib = '0;
   logic [1:0]  iofs = '0, oofs = '0;
   logic [2:0]  iec = '0, oec = '0;
   logic        irdy, oval, olast;
   logic [31:0] ob;
   logic [3:0]  ostrb;
   logic [2:0]  oecv, freeec, availec;

   int n_checks = 0;
   int n_err = 0;

   logic [EW-1:0] exp_q[$];

   rm_stream_aligner #(.EW(EW), .IBEC(IBEC), .OBEC(OBEC), .FIFOEC(FIFOEC)) dut (
      .clk(clk), .rst(rst), .ival(ival), .irdy(irdy), .init(init), .ilast(ilast),
      .ib(ib), .iofs(iofs), .iec(iec), .oval(oval), .ordy(ordy), .ob(ob),
      .ostrb(ostrb), .olast(olast), .oofs(oofs), .oec(oec), .oecv(oecv),
      .freeec(freeec), .availec(availec)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   typedef struct {
      logic rst, ival, init, ilast;
      logic [31:0] ib;
      logic [1:0]  iofs;
      logic [2:0]  iec;
      logic        ordy;
      logic [1:0]  oofs;
      logic [2:0]  oec;
      logic        x_irdy, x_oval;
      logic [31:0] x_ob;
      logic [3:0]  x_ostrb;
      logic        x_olast;
      logic [2:0]  x_oecv, x_freeec, x_availec;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs[NV];

   function automatic vec_t mk(
      input logic r, iv, it, il, input logic [31:0] b, input logic [1:0] io,
      input logic [2:0] ie, input logic od, input logic [1:0] oo, input logic [2:0] oe,
      input logic x_ir, x_ov, input logic [31:0] x_b, input logic [3:0] x_s,
      input logic x_ol, input logic [2:0] x_cv, x_fr, x_av);
      vec_t v;
      v.rst = r; v.ival = iv; v.init = it; v.ilast = il; v.ib = b; v.iofs = io;
      v.iec = ie; v.ordy = od; v.oofs = oo; v.oec = oe;
      v.x_irdy = x_ir; v.x_oval = x_ov; v.x_ob = x_b; v.x_ostrb = x_s;
      v.x_olast = x_ol; v.x_oecv = x_cv; v.x_freeec = x_fr; v.x_availec = x_av;
      return v;
   endfunction

   // scoreboard compare
   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s [%0d]: got %h required %h", name, idx, act, exp);
      end
   endtask

   // driver tasks
   task automatic do_reset();
      rst = 1'b1;
      ival = 0; init = 0; ilast = 0; ib = '0; iofs = '0; iec = '0;
      ordy = 0; oofs = '0; oec = '0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic apply_row(input int r);
      @(posedge clk);
      #1;
      rst = vecs[r].rst; ival = vecs[r].ival; init = vecs[r].init;
      ilast = vecs[r].ilast; ib = vecs[r].ib; iofs = vecs[r].iofs;
      iec = vecs[r].iec; ordy = vecs[r].ordy; oofs = vecs[r].oofs;
      oec = vecs[r].oec;
      @(negedge clk);
      chk("irdy",    r, 32'(irdy),    32'(vecs[r].x_irdy));
      chk("oval",    r, 32'(oval),    32'(vecs[r].x_oval));
      chk("ob",      r, ob,           vecs[r].x_ob);
      chk("ostrb",   r, 32'(ostrb),   32'(vecs[r].x_ostrb));
      chk("olast",   r, 32'(olast),   32'(vecs[r].x_olast));
      chk("oecv",    r, 32'(oecv),    32'(vecs[r].x_oecv));
      chk("freeec",  r, 32'(freeec),  32'(vecs[r].x_freeec));
      chk("availec", r, 32'(availec), 32'(vecs[r].x_availec));
   endtask

   // Streams 10 groups (4,2,4,2,...) through the 6-deep FIFO with 3-element
   // pops, checking byte order across pointer wrap against exp_q.
   task automatic wrap_test();
      int grp = 0;
      int cyc = 0;
      int cnt;
      int exp_cv;
      logic [7:0] nxt = 8'h30;
      logic [31:0] word;
      logic [7:0] e;
      while (!(grp == 10 && exp_q.size() == 0) && cyc < 300) begin
         @(posedge clk);
         #1;
         init = 0; ilast = 0; iofs = '0; oofs = '0; oec = 3'd3;
         ordy = (cyc % 3 != 2);
         if (grp < 10) begin
            ival = 1'b1;
            iec  = (grp % 2 == 0) ? 3'd4 : 3'd2;
            word = '0;
            for (int k = 0; k < int'(iec); k++) word[k*8 +: 8] = nxt + 8'(k);
            ib = word;
         end else begin
            ival = 1'b0; iec = '0; ib = '0;
         end
         @(negedge clk);
         cnt = exp_q.size();
         exp_cv = (cnt < 3) ? cnt : 3;
         chk("wrap_availec", cyc, 32'(availec), 32'(cnt));
         chk("wrap_sum", cyc, 32'(int'(freeec) + int'(availec)), 32'(FIFOEC));
         chk("wrap_irdy", cyc, 32'(irdy), 32'((FIFOEC - cnt) >= int'(iec)));
         chk("wrap_oval", cyc, 32'(oval), 32'(cnt >= 3));
         chk("wrap_oecv", cyc, 32'(oecv), 32'(exp_cv));
         if (oval && ordy) begin
            for (int k = 0; k < int'(oecv); k++) begin
               if (exp_q.size() == 0) begin
                  n_checks++; n_err++;
                  $display("FAIL wrap_underflow [%0d]: got pop with empty model required no pop", cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("wrap_data", cyc, 32'(ob[k*8 +: 8]), 32'(e));
               end
            end
         end
         if (ival && irdy) begin
            for (int k = 0; k < int'(iec); k++) exp_q.push_back(nxt + 8'(k));
            nxt = nxt + 8'(iec);
            grp++;
         end
         cyc++;
      end
      chk("wrap_done_groups", 0, 32'(grp), 32'd10);
      chk("wrap_done_empty", 0, 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
      ival = 0; iec = '0; ordy = 0; oec = '0; ib = '0;
   endtask

   initial begin
      //               rst iv it il ib            io ie od oo oe | irdy oval ob            strb  ol cv fr av
      vecs[0]  = mk(0, 0, 0, 0, 32'h0,        0, 4, 0, 0, 0,  1, 0, 32'h0,        4'h0, 0, 0, 6, 0);
      vecs[1]  = mk(0, 1, 1, 0, 32'h44332211, 1, 3, 0, 2, 2,  1, 0, 32'h0,        4'h0, 0, 0, 6, 0);
      vecs[2]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 2, 2,  1, 1, 32'h33220000, 4'hC, 0, 2, 3, 3);
      vecs[3]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0,  1, 1, 32'h0,        4'h0, 0, 0, 5, 1);
      vecs[4]  = mk(0, 1, 1, 1, 32'hDDCCBBAA, 0, 3, 0, 0, 2,  1, 0, 32'h00000044, 4'h1, 0, 1, 5, 1);
      vecs[5]  = mk(0, 1, 0, 0, 32'h000000EE, 0, 1, 0, 0, 2,  0, 1, 32'h0000BBAA, 4'h3, 0, 2, 3, 3);
      vecs[6]  = mk(0, 1, 0, 0, 32'h000000EE, 0, 1, 1, 0, 2,  0, 1, 32'h0000BBAA, 4'h3, 0, 2, 3, 3);
      vecs[7]  = mk(0, 1, 0, 0, 32'h000000EE, 0, 1, 1, 0, 2,  0, 1, 32'h000000CC, 4'h1, 1, 1, 5, 1);
      vecs[8]  = mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 0, 0,  1, 0, 32'h0,        4'h0, 0, 0, 6, 0);
      vecs[9]  = mk(0, 1, 0, 0, 32'h04030201, 0, 4, 0, 0, 0,  1, 0, 32'h0,        4'h0, 0, 0, 6, 0);
      vecs[10] = mk(0, 1, 0, 0, 32'h00070605, 0, 3, 1, 0, 2,  0, 1, 32'h00000201, 4'h3, 0, 2, 2, 4);
      vecs[11] = mk(0, 1, 0, 0, 32'h00000605, 0, 2, 0, 0, 0,  1, 1, 32'h0,        4'h0, 0, 0, 4, 2);
      vecs[12] = mk(0, 1, 0, 0, 32'h08070000, 2, 2, 1, 1, 3,  1, 1, 32'h05040300, 4'hE, 0, 3, 2, 4);
      vecs[13] = mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 0, 3,  1, 1, 32'h00080706, 4'h7, 0, 3, 3, 3);
      vecs[14] = mk(0, 1, 0, 1, 32'h0,        0, 0, 0, 0, 0,  1, 0, 32'h0,        4'h0, 0, 0, 6, 0);
      vecs[15] = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0,  0, 1, 32'h0,        4'h0, 1, 0, 6, 0);
      vecs[16] = mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 0, 0,  0, 1, 32'h0,        4'h0, 1, 0, 6, 0);
      vecs[17] = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0,  1, 0, 32'h0,        4'h0, 0, 0, 6, 0);
      vecs[18] = mk(0, 1, 0, 1, 32'h14131211, 0, 4, 0, 0, 0,  1, 0, 32'h0,        4'h0, 0, 0, 6, 0);
      vecs[19] = mk(0, 1, 1, 0, 32'h000000F0, 0, 1, 1, 0, 2,  1, 1, 32'h00001211, 4'h3, 0, 2, 2, 4);
      vecs[20] = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 3, 1,  1, 1, 32'hF0000000, 4'h8, 0, 1, 5, 1);
      vecs[21] = mk(0, 1, 0, 1, 32'h00002221, 0, 2, 0, 0, 0,  1, 1, 32'h0,        4'h0, 0, 0, 5, 1);
      vecs[22] = mk(1, 1, 1, 0, 32'hFFFFFFFF, 0, 4, 1, 0, 2,  1, 1, 32'h000021F0, 4'h3, 0, 2, 3, 3);
      vecs[23] = mk(0, 0, 0, 0, 32'h0,        0, 4, 0, 0, 0,  1, 0, 32'h0,        4'h0, 0, 0, 6, 0);

      do_reset();
      for (int r = 0; r < NV; r++) apply_row(r);
      wrap_test();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/rm_stream_aligner.md
Name: rm_stream_aligner

Overview:
- Parametrised successor to the element-realigning FIFO used between AXI vreader/vwriter data paths and the memory bus.
- Accepts variable-count, variable-offset element groups on an input bus and emits re-packed groups at a requested output offset and count.
- New over the previous generation:
  - arbitrary FIFO depth, not tied to IBEC+OBEC;
  - burst-end marking with partial-beat flush;
  - per-element output strobes;
  - zeroing of ob elements whose strobe bit is low.

Parameters:
- EW, 8, element width in bits
- IBEC, 16, input bus element count
- OBEC, 16, output bus element count
- FIFOEC, 32, FIFO depth in elements; must satisfy FIFOEC >= max(IBEC,OBEC) (elaboration-time check)
- Derived: FIFOECW=$clog2(FIFOEC+1), IBECW=$clog2(IBEC+1), OBECW=$clog2(OBEC+1), IOFSW/OOFSW=$clog2(bus count), minimum 1

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ival  in  1  input group valid
- irdy  out  1  input ready
- init  in  1  with an accepted input: discard FIFO contents, start new burst
- ilast  in  1  accepted group is the last of the burst
- ib  in  IBEC*EW  input bus; element i at bits [i*EW+:EW]
- iofs  in  IOFSW  first valid input element
- iec  in  IBECW  input element count
- oval  out  1  output beat valid
- ordy  in  1  output ready
- ob  out  OBEC*EW  output bus
- ostrb  out  OBEC  per-element valid mask for ob
- olast  out  1  beat carries the final elements of the burst
- oofs  in  OOFSW  output placement offset
- oec  in  OBECW  requested output element count
- oecv  out  OBECW  elements actually delivered this beat
- freeec  out  FIFOECW  free element count (registered)
- availec  out  FIFOECW  available element count (registered)

Behaviour:
- Reset: rptr=wptr=0, freeec=FIFOEC, availec=0, last_pend=0.
  - Outputs at reset: oval=0, olast=0, oecv=0, ostrb=0, ob=0.
  - Storage array is not reset.
- Legal inputs: iofs+iec <= IBEC; oofs+oec <= OBEC. Violations are flagged by a simulation assertion; behaviour is undefined.
- Push occurs on ival&&irdy:
  - ib[iofs+k] is written to fifo[(base+k) mod FIFOEC] for k < iec.
  - base = 0 if init, else wptr.
  - wptr <= (base+iec) mod FIFOEC.
- irdy = init | (!last_pend && freeec >= iec).
  - Uses registered freeec only; a same-cycle pop does not bypass into irdy.
  - A zero-count group (iec=0) is accepted whenever !last_pend.
- init push:
  - rptr <= 0, availec <= iec, freeec <= FIFOEC-iec.
  - last_pend <= ilast.
  - Overrides any same-cycle pop; the popped beat is still delivered to the consumer.
- ilast on a non-init push sets last_pend. While last_pend=1, non-init input is blocked.
- oval = (availec >= oec && availec != 0) | last_pend.
- oecv = min(availec, oec).
- ob: element oofs+k = fifo[(rptr+k) mod FIFOEC] for k < oecv; all other elements are 0.
- ostrb has bits oofs..oofs+oecv-1 set.
- olast = last_pend && availec <= oec.
- Output path is combinational from registered state. An element pushed in cycle N is first visible on ob in cycle N+1. There is no input-to-output bypass.
- Pop occurs on oval&&ordy:
  - rptr <= (rptr+oecv) mod FIFOEC.
  - If olast, last_pend <= 0.
- Zero-length flush: last_pend=1 with availec=0 gives oval=1, oecv=0, ostrb=0, olast=1.
- Non-init simultaneous push and pop:
  - availec <= availec + push_cnt - oecv_pop.
  - freeec <= freeec - push_cnt + oecv_pop.
  - Invariant: freeec + availec == FIFOEC.
- Pointer wrap: all pointer arithmetic is modulo FIFOEC, for any FIFOEC, including non-power-of-2 depths.
- Reset asserted mid-burst returns all state to reset values on the next edge. Inputs are ignored during that cycle.

Test Plan:
- Config for all tests: EW=8, IBEC=4, OBEC=4, FIFOEC=6.
- Reset: assert rst 2 cycles -> freeec=6, availec=0, oval=0, ostrb=0, ob=0; irdy=1 for iec=4.
- Realign: init=1, ib elements {0x11,0x22,0x33,0x44}, iofs=1, iec=3 -> next cycle availec=3.
  - Then oofs=2, oec=2 -> oval=1, ob={0,0,0x22,0x33}, ostrb=4'b1100, oecv=2, olast=0.
  - After pop: availec=1, freeec=5.
- Wrap: 6-deep FIFO fed by iec=4 then iec=2, popped with oec=3 repeatedly over 10 groups -> byte sequence preserved across pointer wrap at 6; freeec+availec=6 every cycle.
- Flush: init push iec=3, ilast=1; later non-init push with ival=1 -> irdy=0.
  - Pop oec=2 -> oecv=2, olast=0.
  - Second beat -> oecv=1, ostrb=4'b0001 (oofs=0), olast=1.
  - After pop: last_pend=0, irdy=1.
- Full and simultaneous: freeec=2, iec=3 -> irdy=0 even with a same-cycle pop of 2.
  - Next cycle freeec=4 -> irdy=1.
  - Concurrent push 2 / pop 3 -> availec net change -1.
- Zero-length last and init override:
  - Push iec=0, ilast=1 on empty FIFO -> oval=1, oecv=0, olast=1.
  - With availec=4 and last_pend=1, an init push iec=1 in the same cycle as a pop -> availec=1, last_pend=ilast.
  - Mid-burst rst -> all counters back to reset values.
